// File: rtl/uart_rx_cmd_decoder.sv
// UART RX command decoder: turns received byte frames into RF write/read and ALU strobes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder #(
    parameter int unsigned Data_Width  = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FUN_W       = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Parity_Error,
    input  logic                  Stop_Error,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_W-1:0]     RF_Address,
    output logic [Data_Width-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [FUN_W-1:0]      ALU_FUN,
    output logic                  Busy,
    output logic                  Cmd_Err
);

    localparam logic [Data_Width-1:0] OpWrite = Data_Width'(8'hAA);
    localparam logic [Data_Width-1:0] OpRead  = Data_Width'(8'hBB);
    localparam logic [Data_Width-1:0] OpAlu   = Data_Width'(8'hCC);
    localparam logic [Data_Width-1:0] OpFun   = Data_Width'(8'hDD);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StFun
    } state_e;

    state_e              state_q, state_d;
    logic                dv_q;
    logic [ADDR_W-1:0]   hold_q;
    logic                frame_err;
    logic                accept;
    logic                is_opcode;
    logic                timeout;

    assign frame_err = Parity_Error | Stop_Error;
    assign accept    = Data_Valid & ~dv_q & ~frame_err;
    assign is_opcode = (P_DATA == OpWrite) || (P_DATA == OpRead) ||
                       (P_DATA == OpAlu)   || (P_DATA == OpFun);

`ifdef CMD_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Restarts on every accepted byte; parked at zero while idle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StIdle || accept) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign timeout = (state_q != StIdle) && (tmo_cnt_q == TIMEOUT_CYC - 16'd1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (frame_err || timeout) begin
            state_d = StIdle;
        end else if (accept) begin
            case (state_q)
                StIdle: begin
                    if (P_DATA == OpWrite)     state_d = StWrAddr;
                    else if (P_DATA == OpRead) state_d = StRdAddr;
                    else if (P_DATA == OpAlu)  state_d = StOpA;
                    else if (P_DATA == OpFun)  state_d = StFun;
                end
                StWrAddr: state_d = StWrData;
                StOpA:    state_d = StOpB;
                StOpB:    state_d = StFun;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            dv_q       <= 1'b0;
            hold_q     <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            Busy       <= 1'b0;
            Cmd_Err    <= 1'b0;
        end else begin
            state_q <= state_d;
            Busy    <= (state_d != StIdle);
            dv_q    <= Data_Valid;
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;
            Cmd_Err <= 1'b0;
            // Receiver errors and timeout win over any byte arriving the same cycle.
            if (frame_err || timeout) begin
                Cmd_Err <= 1'b1;
            end else if (accept) begin
                case (state_q)
                    StIdle:   Cmd_Err <= ~is_opcode;
                    StWrAddr: hold_q  <= P_DATA[ADDR_W-1:0];
                    StWrData: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= hold_q;
                        RF_WrData  <= P_DATA;
                    end
                    StRdAddr: begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= P_DATA[ADDR_W-1:0];
                    end
                    StOpA: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= '0;
                        RF_WrData  <= P_DATA;
                    end
                    StOpB: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_W'(1);
                        RF_WrData  <= P_DATA;
                    end
                    StFun: begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= P_DATA[FUN_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: frame-level reference model checked every cycle,
// plus directed command sequences with literal expectations.
module tb_uart_rx_cmd_decoder;

    localparam int TO = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DV = 1'b0;
    logic       PE = 1'b0;
    logic       SE = 1'b0;

    logic       RF_WrEn, RF_RdEn, ALU_EN, Busy, Cmd_Err;
    logic [3:0] RF_Address, ALU_FUN;
    logic [7:0] RF_WrData;

    uart_rx_cmd_decoder #(
        .Data_Width (8),
        .ADDR_W     (4),
        .FUN_W      (4),
        .TIMEOUT_CYC(16'(TO))
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .Data_Valid  (DV),
        .Parity_Error(PE),
        .Stop_Error  (SE),
        .RF_WrEn     (RF_WrEn),
        .RF_RdEn     (RF_RdEn),
        .RF_Address  (RF_Address),
        .RF_WrData   (RF_WrData),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .Busy        (Busy),
        .Cmd_Err     (Cmd_Err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit check_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the bytes of the frame in progress.
    logic [7:0] frame[$];
    logic       m_prev_dv = 1'b0;
    int         m_cnt = 0;
    logic       e_wr = 0, e_rd = 0, e_alu = 0, e_busy = 0, e_err = 0;
    logic [3:0] e_addr = 0, e_fun = 0;
    logic [7:0] e_wdata = 0;

    always @(posedge CLK) begin
        logic acc, busy_before, tmo;
        int   n;
        if (!RST) begin
            frame.delete();
            m_prev_dv = 0; m_cnt = 0;
            e_wr = 0; e_rd = 0; e_alu = 0; e_busy = 0; e_err = 0;
            e_addr = 0; e_fun = 0; e_wdata = 0;
        end else begin
            acc = DV && !m_prev_dv && !PE && !SE;
            busy_before = (frame.size() > 0);
`ifdef CMD_TIMEOUT_EN
            tmo = busy_before && (m_cnt == TO - 1);
`else
            tmo = 1'b0;
`endif
            m_cnt = (!busy_before || acc) ? 0 : m_cnt + 1;
            e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
            if (PE || SE || tmo) begin
                frame.delete();
                e_err = 1;
            end else if (acc) begin
                if (frame.size() == 0) begin
                    if (P_DATA inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) frame.push_back(P_DATA);
                    else e_err = 1;
                end else begin
                    frame.push_back(P_DATA);
                    n = frame.size();
                    case (frame[0])
                        8'hAA: if (n == 3) begin
                            e_wr = 1; e_addr = frame[1][3:0]; e_wdata = frame[2];
                            frame.delete();
                        end
                        8'hBB: begin
                            e_rd = 1; e_addr = frame[1][3:0];
                            frame.delete();
                        end
                        8'hCC: begin
                            if (n == 4) begin
                                e_alu = 1; e_fun = P_DATA[3:0];
                                frame.delete();
                            end else begin
                                e_wr = 1; e_addr = (n == 2) ? 4'd0 : 4'd1; e_wdata = P_DATA;
                            end
                        end
                        default: begin
                            e_alu = 1; e_fun = P_DATA[3:0];
                            frame.delete();
                        end
                    endcase
                end
            end
            m_prev_dv = DV;
            e_busy = (frame.size() > 0);
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            check("RF_WrEn", RF_WrEn, e_wr);
            check("RF_RdEn", RF_RdEn, e_rd);
            check("ALU_EN", ALU_EN, e_alu);
            check("RF_Address", RF_Address, e_addr);
            check("RF_WrData", RF_WrData, e_wdata);
            check("ALU_FUN", ALU_FUN, e_fun);
            check("Busy", Busy, e_busy);
            check("Cmd_Err", Cmd_Err, e_err);
        end
    end

    // Strobe log used by the literal expectations.
    logic [3:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    int         rd_cnt = 0, alu_cnt = 0, err_cnt = 0, err_cyc = 0, acc_cyc = 0;
    logic [3:0] last_rd_addr = 0, last_fun = 0;

    always @(negedge CLK) begin
        if (RF_WrEn === 1'b1) begin
            wr_addr_log.push_back(RF_Address);
            wr_data_log.push_back(RF_WrData);
        end
        if (RF_RdEn === 1'b1) begin
            rd_cnt++; last_rd_addr = RF_Address;
        end
        if (ALU_EN === 1'b1) begin
            alu_cnt++; last_fun = ALU_FUN;
        end
        if (Cmd_Err === 1'b1) begin
            err_cnt++; err_cyc = cyc;
        end
    end

    task automatic clear_log();
        wr_addr_log.delete(); wr_data_log.delete();
        rd_cnt = 0; alu_cnt = 0; err_cnt = 0;
    endtask

    function automatic logic [31:0] wr_a(input int i);
        return (i < wr_addr_log.size()) ? 32'(wr_addr_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wr_d(input int i);
        return (i < wr_data_log.size()) ? 32'(wr_data_log[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic send(input logic [7:0] b, input int hold);
        P_DATA = b; DV = 1'b1;
        repeat (hold) @(negedge CLK);
        DV = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        check_en = 1'b1;
        @(negedge CLK);
        check("reset Busy", Busy, 0);
        check("reset Cmd_Err", Cmd_Err, 0);
        check("reset RF_Address", RF_Address, 0);
        check("reset RF_WrEn", RF_WrEn, 0);
        RST = 1'b1;
        @(negedge CLK);

        // Write command with Data_Valid held for several cycles per byte
        clear_log();
        send(8'hAA, 4); send(8'h05, 4); send(8'h3C, 4);
        check("wr count", wr_addr_log.size(), 1);
        check("wr addr", wr_a(0), 5);
        check("wr data", wr_d(0), 8'h3C);
        check("wr no read", rd_cnt, 0);
        check("wr Busy after", Busy, 0);

        // Read command
        clear_log();
        send(8'hBB, 2); send(8'h0A, 2);
        check("rd count", rd_cnt, 1);
        check("rd addr", last_rd_addr, 4'hA);
        check("rd no write", wr_addr_log.size(), 0);

        // ALU command with two operand writes
        clear_log();
        send(8'hCC, 2); send(8'h12, 3); send(8'h34, 1); send(8'h02, 2);
        check("alu wr count", wr_addr_log.size(), 2);
        check("opa addr", wr_a(0), 0);
        check("opa data", wr_d(0), 8'h12);
        check("opb addr", wr_a(1), 1);
        check("opb data", wr_d(1), 8'h34);
        check("alu count", alu_cnt, 1);
        check("alu fun", last_fun, 2);

        // Unknown opcode, then function-only command
        clear_log();
        send(8'h7E, 2);
        check("badop err", err_cnt, 1);
        check("badop Busy", Busy, 0);
        clear_log();
        send(8'hDD, 2); send(8'h01, 2);
        check("fun count", alu_cnt, 1);
        check("fun value", last_fun, 1);

        // Parity error on the data byte aborts the write
        clear_log();
        send(8'hAA, 2); send(8'h03, 2);
        P_DATA = 8'h55; DV = 1'b1; PE = 1'b1;
        @(negedge CLK);
        PE = 1'b0;
        repeat (3) @(negedge CLK);
        DV = 1'b0;
        repeat (2) @(negedge CLK);
        check("parity err", err_cnt, 1);
        check("parity no write", wr_addr_log.size(), 0);
        check("parity Busy", Busy, 0);

        // Stop error while idle still pulses Cmd_Err
        clear_log();
        SE = 1'b1;
        @(negedge CLK);
        SE = 1'b0;
        repeat (2) @(negedge CLK);
        check("stop err", err_cnt, 1);

        // Reset in the middle of a command
        clear_log();
        send(8'hAA, 2); send(8'h07, 2);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst err", err_cnt, 0);
        check("rst no write", wr_addr_log.size(), 0);
        check("rst Busy", Busy, 0);

        // Stalled frame after a read opcode
        clear_log();
        P_DATA = 8'hBB; DV = 1'b1;
        @(posedge CLK);
        #1 acc_cyc = cyc;
        @(negedge CLK);
        DV = 1'b0;
        repeat (25) @(negedge CLK);
`ifdef CMD_TIMEOUT_EN
        check("timeout err", err_cnt, 1);
        check("timeout latency", err_cyc - acc_cyc, TO);
        check("timeout Busy", Busy, 0);
`else
        check("stall Busy", Busy, 1);
        check("stall err", err_cnt, 0);
`endif
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
